uart_ram_loader: RTL and testbench
==================================

Name: uart_ram_loader

Overview:
- Host-to-RAM program loader. Receives a length-prefixed stream of 16-bit words over a UART serial line (8N1, LSB first) and writes the words to sequential RAM addresses starting at 0.
- Drives the RAM write port (w_en, w_addr, w_data) while the CPU is held off.
- It is the writer end of the RAM: the CPU datapath later reads the image through MAR/MDR instead of relying on ram_mem_init.txt.

Parameters:
- CLKS_PER_BIT, 104, clocks per UART bit (12 MHz / 115200); must be >= 4
- ADDR_WIDTH, 12, RAM address width
- DATA_WIDTH, 16, word width; fixed as two bytes, high byte first
- MEM_DEPTH, 4096, maximum accepted word count

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- rx  input  1  UART serial in; idle high; asynchronous to clk
- load_en  input  1  level; 1 = accept a load, 0 = abort/idle
- w_en  output  1  RAM write strobe, one-cycle pulse per word
- w_addr  output  ADDR_WIDTH  RAM write address
- w_data  output  DATA_WIDTH  RAM write data
- busy  output  1  load in progress; top level holds the CPU off while high
- done  output  1  level; image loaded successfully
- err  output  1  level; framing error or oversize count
- words_loaded  output  16  count of words written so far

Behaviour:
Reset values:
- w_en=0, w_addr=0, w_data=0, busy=0, done=0, err=0, words_loaded=0, FSM=IDLE.
- Synchronizer flops reset to 1.

Receiver (uart_rx):
- rx passes through a 2-flop synchronizer.
- Start is detected on a falling edge and re-checked at CLKS_PER_BIT/2. If rx is high at that check, it is a glitch and the receiver returns to idle.
- The 8 data bits are sampled at bit centres, LSB first.
- The stop bit is sampled at its centre.
  - Stop = 1: byte_valid pulses for 1 cycle with the byte.
  - Stop = 0: frame_err pulses for 1 cycle and the byte is dropped.
- The receiver is re-armed for the next start edge immediately after the stop-bit sample.

Stream format:
- CNT_HI, CNT_LO: 16-bit word count N, big-endian.
- Then N words, each as two bytes, high byte first.

FSM states: IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, DONE, ERROR.
- IDLE: entered when load_en=0. Leaves to CNT_HI when load_en=1. Entering CNT_HI clears done, err, words_loaded and w_addr.
- CNT_HI: on byte_valid, latch count[15:8] -> CNT_LO. busy=1 from CNT_HI onward.
- CNT_LO: on byte_valid, latch count[7:0]. Then:
  - N=0 -> DONE.
  - N>MEM_DEPTH -> ERROR.
  - Otherwise -> DAT_HI.
- DAT_HI: on byte_valid, latch w_data[15:8] -> DAT_LO.
- DAT_LO: on byte_valid, latch w_data[7:0] -> WRITE.
- WRITE: w_en=1 for exactly this cycle, with w_addr/w_data stable.
  - Next cycle: w_addr+1, words_loaded+1.
  - If words_loaded+1 == N -> DONE, else -> DAT_HI.
  - Latency: w_en is high exactly 1 cycle after the low byte's byte_valid.
- DONE: busy=0, done=1. Holds until load_en=0.
- ERROR: busy=0, err=1, no further writes. Holds until load_en=0.

Boundary conditions:
- frame_err in any of CNT_HI..DAT_LO -> ERROR. Words already written remain in RAM.
- N=MEM_DEPTH: the final write uses w_addr=MEM_DEPTH-1. w_addr does not wrap into a further write, because the FSM exits to DONE.
- load_en falling in any state -> IDLE next cycle; busy=0, no w_en.
  - If it falls in WRITE, the pending w_en in that cycle still completes.
  - done/err keep their last values until the next CNT_HI entry.
- Bytes received in IDLE, DONE or ERROR are ignored.
- reset asserted mid-byte or mid-load: all state clears immediately (asynchronous). The partial image is not rolled back.

Decomposition:
- Shared package loader_pkg:
  - FSM state enum.
  - UART framing constants (8 data bits, 1 stop bit).
  - Byte order: high byte first.
- One sub-module uart_rx (clk, reset, rx, byte_out[7:0], byte_valid, frame_err), parameterized by CLKS_PER_BIT.
- uart_ram_loader contains the FSM, the address/data/count registers and the write strobe.

Test Plan:
1. CLKS_PER_BIT=4, load_en=1, send 00 03, then 12 34, AB CD, 00 07:
   - three w_en pulses: (addr 0, 1234), (addr 1, ABCD), (addr 2, 0007);
   - then done=1, busy=0, words_loaded=3.
2. Send count 00 00 -> done=1 with no w_en pulse; w_addr=0.
3. Send count 10 01 (4097 > MEM_DEPTH) -> err=1, no w_en; later bytes are ignored.
4. Count 00 02; the first word is good; the second word's low byte has stop bit=0:
   - exactly one w_en (addr 0);
   - err=1, words_loaded=1.
5. 1-clock low glitch on rx while idle -> no byte_valid, FSM still in CNT_HI. Then drop load_en mid-word -> busy=0 and no w_en. Re-raise load_en and send a full 1-word image -> write lands at addr 0.
6. Assert reset during DAT_LO -> all outputs return to their reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/uart_ram_loader_pkg.sv
// Shared types and constants for the UART RAM loader: FSM states,
// UART framing and the big-endian byte order of the host stream.
package loader_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // Loader FSM
  // state     | meaning
  // ST_IDLE   | load_en low, nothing in progress
  // ST_CNT_HI | waiting for word count, high byte
  // ST_CNT_LO | waiting for word count, low byte; range check
  // ST_DAT_HI | waiting for data word, high byte
  // ST_DAT_LO | waiting for data word, low byte
  // ST_WRITE  | w_en asserted for this single cycle
  // ST_DONE   | image complete, holds until load_en drops
  // ST_ERROR  | framing error or oversize count, holds until load_en drops
  typedef enum logic [2:0] {
    ST_IDLE, ST_CNT_HI, ST_CNT_LO, ST_DAT_HI,
    ST_DAT_LO, ST_WRITE, ST_DONE, ST_ERROR
  } state_t;

  // Receiver: waiting for edge, confirming start bit, sampling data+stop bits
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_t;

  // Host sends the high byte first.
  function automatic logic [15:0] be_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/uart_ram_loader_if.sv
// RAM write port plus load status, driven by the loader (master).
interface uart_ram_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [15:0]           words_loaded;

  modport master (output w_en, w_addr, w_data, busy, done, err, words_loaded);
  modport slave  (input  w_en, w_addr, w_data, busy, done, err, words_loaded);
endinterface

// File: rtl/uart_ram_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit confirmation at half
// a bit, centre sampling, one-cycle byte_valid / frame_err pulses.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] DATA_END = 4'(UART_DATA_BITS);
  localparam logic [3:0] LAST_IDX = 4'(UART_DATA_BITS + UART_STOP_BITS - 1);

  logic rx_meta, rx_sync, rx_prev;
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx;
  logic [7:0] shreg;

  // Synchronize rx and keep one extra stage for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit timing via a down-counter; sample when it reaches zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            cnt   <= HALF_M1;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            if (rx_sync) begin
              state <= RX_IDLE;
            end else begin
              cnt     <= FULL_M1;
              bit_idx <= '0;
              state   <= RX_BITS;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_BITS: begin
          if (cnt == '0) begin
            cnt <= FULL_M1;
            if (bit_idx < DATA_END) begin
              shreg   <= {rx_sync, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end else if (bit_idx < LAST_IDX) begin
              // leading stop bits of a multi-stop frame; only the last is checked
              bit_idx <= bit_idx + 1'b1;
            end else begin
              state <= RX_IDLE;
              if (rx_sync) begin
                byte_out   <= shreg;
                byte_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_ram_loader.sv
// Host-to-RAM loader: parses a big-endian word count followed by that many
// 16-bit words from the UART and writes them to RAM from address 0.
module uart_ram_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_DEPTH    = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic load_en,
  uart_ram_loader_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [16:0] DEPTH_MAX = 17'(MEM_DEPTH);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ferr;
  state_t      state;
  logic [15:0] count;
  logic [15:0] n_rx;
  logic [15:0] words_next;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr)
  );

  assign n_rx       = be_word(count[15:8], rx_byte);
  assign words_next = bus.words_loaded + 16'd1;

  // Loader FSM with registered write strobe and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      count            <= '0;
      bus.w_en         <= 1'b0;
      bus.w_addr       <= '0;
      bus.w_data       <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.err          <= 1'b0;
      bus.words_loaded <= '0;
    end else begin
      bus.w_en <= 1'b0;
      if (!load_en) begin
        state    <= ST_IDLE;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state            <= ST_CNT_HI;
            bus.busy         <= 1'b1;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
            bus.words_loaded <= '0;
            bus.w_addr       <= '0;
          end
          ST_CNT_HI: begin
            if (rx_ferr) begin
              state <= ST_ERROR; bus.busy <= 1'b0; bus.err <= 1'b1;
            end else if (rx_valid) begin
              count[15:8] <= rx_byte;
              state       <= ST_CNT_LO;
            end
          end
          ST_CNT_LO: begin
            if (rx_ferr) begin
              state <= ST_ERROR; bus.busy <= 1'b0; bus.err <= 1'b1;
            end else if (rx_valid) begin
              count <= n_rx;
              if (n_rx == 16'd0) begin
                state <= ST_DONE; bus.busy <= 1'b0; bus.done <= 1'b1;
              end else if ({1'b0, n_rx} > DEPTH_MAX) begin
                state <= ST_ERROR; bus.busy <= 1'b0; bus.err <= 1'b1;
              end else begin
                state <= ST_DAT_HI;
              end
            end
          end
          ST_DAT_HI: begin
            if (rx_ferr) begin
              state <= ST_ERROR; bus.busy <= 1'b0; bus.err <= 1'b1;
            end else if (rx_valid) begin
              bus.w_data[DATA_WIDTH-1 -: 8] <= rx_byte;
              state <= ST_DAT_LO;
            end
          end
          ST_DAT_LO: begin
            if (rx_ferr) begin
              state <= ST_ERROR; bus.busy <= 1'b0; bus.err <= 1'b1;
            end else if (rx_valid) begin
              bus.w_data[7:0] <= rx_byte;
              bus.w_en        <= 1'b1;
              state           <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            bus.w_addr       <= bus.w_addr + ADDR_ONE;
            bus.words_loaded <= words_next;
            if (words_next == count) begin
              state <= ST_DONE; bus.busy <= 1'b0; bus.done <= 1'b1;
            end else begin
              state <= ST_DAT_HI;
            end
          end
          ST_DONE, ST_ERROR: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Bench for uart_ram_loader: directed and random images through a serial
// driver, checked against a stream-level model of the load protocol.
`timescale 1ns/1ps
module tb_uart_ram_loader;
  localparam int CPB   = 4;
  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic load_en = 1'b0;

  always #5 clk = ~clk;

  uart_ram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  uart_ram_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .load_en(load_en), .bus(bus)
  );

  typedef struct { int addr; int data; } wr_t;

  int n_pass = 0;
  int n_total = 0;
  wr_t exp_q[$];
  int exp_done, exp_err, exp_words, exp_busy;
  byte unsigned img[$];
  bit bad[$];

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic img_clear();
    img.delete();
    bad.delete();
  endtask

  task automatic add(input byte unsigned b, input bit bd = 1'b0);
    img.push_back(b);
    bad.push_back(bd);
  endtask

  // Stream-level model: what the loader must write and report given the bytes sent.
  task automatic model_load();
    int n;
    exp_done = 0; exp_err = 0; exp_words = 0; exp_busy = 1;
    for (int i = 0; i < 2; i++)
      if (i < img.size() && bad[i]) begin exp_err = 1; exp_busy = 0; return; end
    if (img.size() < 2) return;
    n = int'(img[0]) * 256 + int'(img[1]);
    if (n == 0) begin exp_done = 1; exp_busy = 0; return; end
    if (n > DEPTH) begin exp_err = 1; exp_busy = 0; return; end
    for (int k = 0; k < n; k++) begin
      if ((2 + 2*k < img.size() && bad[2 + 2*k]) || (3 + 2*k < img.size() && bad[3 + 2*k])) begin
        exp_err = 1; exp_busy = 0; return;
      end
      if (img.size() < 4 + 2*k) return;
      exp_q.push_back('{k % DEPTH, int'(img[2 + 2*k]) * 256 + int'(img[3 + 2*k])});
      exp_words++;
    end
    exp_done = 1; exp_busy = 0;
  endtask

  task automatic send_byte(input byte unsigned b, input bit stop);
    rx = 1'b0; cyc(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; cyc(CPB); end
    rx = stop; cyc(CPB);
    rx = 1'b1; cyc(2*CPB);
  endtask

  task automatic send_all();
    for (int i = 0; i < img.size(); i++) send_byte(img[i], !bad[i]);
  endtask

  task automatic start_load();
    load_en = 1'b0; cyc(2);
    load_en = 1'b1; cyc(2);
  endtask

  task automatic finish_check(input string tag);
    int t = 0;
    if (exp_busy == 0) begin
      while (!(bus.done || bus.err) && t < 300) begin cyc(1); t++; end
      if (t >= 300) check({tag, "_timeout"}, 0, 1);
    end
    cyc(2);
    check({tag, "_busy"},  bus.busy, exp_busy);
    check({tag, "_done"},  bus.done, exp_done);
    check({tag, "_err"},   bus.err,  exp_err);
    check({tag, "_words"}, bus.words_loaded, exp_words);
    check({tag, "_addr"},  bus.w_addr, exp_words % DEPTH);
    check({tag, "_writes_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic build_random();
    int n, mode, cnt16;
    img_clear();
    n = $urandom_range(1, 5);
    mode = $urandom_range(0, 9);
    cnt16 = (mode == 0) ? $urandom_range(4097, 65535) : n;
    add(8'(cnt16 >> 8));
    add(8'(cnt16));
    for (int k = 0; k < 2*n; k++) add(8'($urandom));
    if ($urandom_range(0, 1) == 1) add(8'($urandom));
    if (mode >= 1 && mode <= 3) bad[$urandom_range(0, img.size() - 1)] = 1'b1;
  endtask

  // Every write strobe must match the next write the model predicts.
  always @(negedge clk) begin : cmp
    wr_t e;
    if (reset && bus.w_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_w_en", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("w_addr", bus.w_addr, e.addr);
        check("w_data", bus.w_data, e.data);
      end
      check("busy_during_write", bus.busy, 1);
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    cyc(3);
    check("rst_w_en",  bus.w_en, 0);
    check("rst_w_addr", bus.w_addr, 0);
    check("rst_w_data", bus.w_data, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_done",  bus.done, 0);
    check("rst_err",   bus.err, 0);
    check("rst_words", bus.words_loaded, 0);
    reset = 1'b1;
    cyc(3);

    // 1: three-word image
    start_load();
    img_clear();
    add(8'h00); add(8'h03); add(8'h12); add(8'h34);
    add(8'hAB); add(8'hCD); add(8'h00); add(8'h07);
    model_load();
    check("model_t1_n", exp_q.size(), 3);
    check("model_t1_a2", exp_q[2].addr, 2);
    check("model_t1_d0", exp_q[0].data, 'h1234);
    check("model_t1_d1", exp_q[1].data, 'hABCD);
    check("model_t1_d2", exp_q[2].data, 'h0007);
    send_all();
    finish_check("t1");
    check("t1_lit_words", bus.words_loaded, 3);
    check("t1_lit_done", bus.done, 1);

    // 2: empty image
    start_load();
    img_clear(); add(8'h00); add(8'h00);
    model_load(); send_all(); finish_check("t2");
    check("t2_lit_addr", bus.w_addr, 0);
    check("t2_lit_done", bus.done, 1);

    // 3: oversize count, later bytes ignored
    start_load();
    img_clear(); add(8'h10); add(8'h01); add(8'h12); add(8'h34); add(8'h56); add(8'h78);
    model_load(); send_all(); finish_check("t3");
    check("t3_lit_err", bus.err, 1);

    // 4: framing error on the second word's low byte
    start_load();
    img_clear(); add(8'h00); add(8'h02); add(8'hAA); add(8'h55); add(8'h66); add(8'h77, 1'b1);
    model_load(); send_all(); finish_check("t4");
    check("t4_lit_words", bus.words_loaded, 1);
    check("t4_lit_err", bus.err, 1);

    // 5a: one-clock glitch in CNT_HI must not produce a byte
    start_load();
    rx = 1'b0; cyc(1); rx = 1'b1; cyc(20);
    check("t5_glitch_busy", bus.busy, 1);
    img_clear(); add(8'h00); add(8'h01); add(8'h5A); add(8'hA5);
    model_load(); send_all(); finish_check("t5_glitch");

    // 5b: count == MEM_DEPTH is accepted; abort mid-word
    start_load();
    img_clear(); add(8'h10); add(8'h00); add(8'h11); add(8'h11); add(8'h22); add(8'h22); add(8'h33);
    model_load(); send_all(); finish_check("t5_pre_abort");
    load_en = 1'b0; cyc(1);
    check("t5_abort_busy", bus.busy, 0);
    send_byte(8'h44, 1'b1);
    check("t5_abort_done", bus.done, 0);
    check("t5_abort_err", bus.err, 0);
    start_load();
    img_clear(); add(8'h00); add(8'h01); add(8'hBE); add(8'hEF);
    model_load();
    check("model_t5_addr0", exp_q[0].addr, 0);
    send_all(); finish_check("t5_reload");

    // 6: asynchronous reset while in DAT_LO
    start_load();
    img_clear(); add(8'h00); add(8'h02); add(8'hAA); add(8'hBB); add(8'hCC);
    model_load(); send_all(); finish_check("t6_pre");
    #2 reset = 1'b0;
    #1;
    check("t6_w_en",  bus.w_en, 0);
    check("t6_w_addr", bus.w_addr, 0);
    check("t6_w_data", bus.w_data, 0);
    check("t6_busy",  bus.busy, 0);
    check("t6_done",  bus.done, 0);
    check("t6_err",   bus.err, 0);
    check("t6_words", bus.words_loaded, 0);
    cyc(2);
    reset = 1'b1;
    cyc(2);

    // random images
    for (int r = 0; r < 10; r++) begin
      start_load();
      build_random();
      model_load();
      send_all();
      finish_check($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
